// File: rtl/relprime_pkg.sv
// Shared types and defaults for the relprime sequencing controller.
package relprime_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GCD   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } relprime_state_t;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_M_FIRST = 2;
endpackage

// File: rtl/gcd_step.sv
// One subtractive-Euclid step: the larger operand is reduced by the smaller.
module gcd_step #(
  parameter int unsigned WIDTH = relprime_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic             eq
);
  always_comb begin
    a_next = a;
    b_next = b;
    eq     = (a == b);
    if (a > b)
      a_next = a - b;
    else if (b > a)
      b_next = b - a;
  end
endmodule

// File: rtl/relprime_ctrl.sv
// Finds the smallest m >= M_FIRST coprime with n using one subtractive GCD
// step per cycle, reported through a busy/done handshake.
module relprime_ctrl
  import relprime_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned M_FIRST = DEF_M_FIRST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam logic [WIDTH-1:0] M_INIT = WIDTH'(M_FIRST);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  relprime_state_t  state;
  logic [WIDTH-1:0] nreg;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             eq;
  logic [WIDTH-1:0] m_inc;

  assign m_inc = m + ONE;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .b      (b),
    .a_next (a_next),
    .b_next (b_next),
    .eq     (eq)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      nreg   <= '0;
      m      <= '0;
      a      <= '0;
      b      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (n == '0) begin
              result <= '0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              nreg  <= n;
              m     <= M_INIT;
              a     <= n;
              b     <= M_INIT;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= S_GCD;
            end
          end
        end
        S_GCD: begin
          if (eq) begin
            state <= S_CHECK;
          end else begin
            a <= a_next;
            b <= b_next;
          end
        end
        S_CHECK: begin
          // a holds gcd(nreg, m) here; 1 means the candidate is coprime.
          if (a == ONE) begin
            result <= m;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            m     <= m_inc;
            a     <= nreg;
            b     <= m_inc;
            state <= S_GCD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relprime_ctrl.sv
// Self-checking bench for relprime_ctrl against an arithmetic reference model.
module tb_relprime_ctrl;
  logic        CLK;
  logic        RST;
  logic        start;
  logic [15:0] n;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        err;

  int tests;
  int fails;

  relprime_ctrl #(.WIDTH(16), .M_FIRST(2)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Smallest coprime m >= 2 and the cycle count from accept edge to DONE edge:
  // each candidate costs its subtraction steps, one equality cycle and one check.
  function automatic void model(input logic [15:0] nv, output logic [15:0] r,
                                output logic e, output int lat);
    int x;
    int y;
    r   = '0;
    e   = 1'b0;
    lat = 0;
    if (nv == 16'd0) begin
      e = 1'b1;
      return;
    end
    for (int m = 2; m < 100; m++) begin
      x = int'(nv);
      y = m;
      while (x != y) begin
        if (x > y) x = x - y;
        else       y = y - x;
        lat++;
      end
      lat += 2;
      if (x == 1) begin
        r = 16'(m);
        return;
      end
    end
  endfunction

  task automatic idle_cycles(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Single request from IDLE; checks latency, busy span, outputs and pulse width.
  task automatic test_compute(input logic [15:0] val);
    logic [15:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    model(val, exp_r, exp_e, exp_lat);
    start = 1'b1;
    n     = val;
    @(posedge CLK);
    #1;
    start    = 1'b0;
    n        = $urandom;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < exp_lat + 50) begin
      if (busy) busy_cnt++;
      @(posedge CLK);
      #1;
      lat++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL timeout n=%0d: done=%b after %0d cycles, required 1", val, done, lat);
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL latency n=%0d: got %0d, required %0d", val, lat, exp_lat);
    end
    tests++;
    if (result !== exp_r) begin
      fails++;
      $display("FAIL result n=%0d: got %0d, required %0d", val, result, exp_r);
    end
    tests++;
    if (err !== exp_e) begin
      fails++;
      $display("FAIL err n=%0d: got %b, required %b", val, err, exp_e);
    end
    tests++;
    if (busy !== 1'b0 || busy_cnt !== exp_lat) begin
      fails++;
      $display("FAIL busy n=%0d: busy=%b span=%0d, required 0 span=%0d", val, busy, busy_cnt, exp_lat);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (done !== 1'b0 || result !== exp_r || err !== exp_e) begin
      fails++;
      $display("FAIL hold n=%0d: done=%b result=%0d err=%b, required 0 %0d %b", val, done, result, err, exp_r, exp_e);
    end
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    start = 1'b0;
    n     = '0;
    #12;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%0d err=%b, required all 0", busy, done, result, err);
    end
    for (int i = 0; i < 20; i++) begin
      n = $urandom;
      @(posedge CLK);
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%0d, required 0", i, busy, done, result);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] vals [7] = '{16'd1, 16'd2, 16'd6, 16'd30, 16'd65535, 16'd0, 16'd1};
    foreach (vals[i]) begin
      test_compute(vals[i]);
      idle_cycles(1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_compute(16'($urandom_range(1, 400)));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          dones;
    int          first;
    model(16'd30, exp_r, exp_e, exp_lat);
    start = 1'b1;
    n     = 16'd30;
    @(posedge CLK);
    #1;
    start = 1'b0;
    dones = 0;
    first = -1;
    for (int c = 1; c <= exp_lat + 30; c++) begin
      start = (c == 3);
      n     = (c == 3) ? 16'd1 : 16'd0;
      @(posedge CLK);
      #1;
      if (done) begin
        dones++;
        if (first < 0) first = c;
      end
    end
    start = 1'b0;
    tests++;
    if (dones !== 1 || first !== exp_lat) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d at %0d, required 1 at %0d", dones, first, exp_lat);
    end
    tests++;
    if (result !== exp_r) begin
      fails++;
      $display("FAIL ignore_start result: got %0d, required %0d", result, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          c;
    int          seen;
    int          last;
    model(16'd6, exp_r, exp_e, exp_lat);
    start = 1'b1;
    n     = 16'd6;
    @(posedge CLK);
    #1;
    c    = 0;
    seen = 0;
    last = 0;
    while (seen < 3 && c < 4 * (exp_lat + 2)) begin
      if (done) begin
        tests++;
        if (c - last !== (seen == 0 ? exp_lat : exp_lat + 2) || result !== exp_r) begin
          fails++;
          $display("FAIL back_to_back #%0d: gap=%0d result=%0d, required gap=%0d result=%0d",
                   seen, c - last, result, (seen == 0 ? exp_lat : exp_lat + 2), exp_r);
        end
        last = c;
        seen++;
        if (seen == 3) start = 1'b0;
      end
      if (seen < 3) begin
        @(posedge CLK);
        #1;
        c++;
      end
    end
    start = 1'b0;
    tests++;
    if (seen !== 3) begin
      fails++;
      $display("FAIL back_to_back count: got %0d dones, required 3", seen);
    end
    idle_cycles(3);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back release: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    start = 1'b1;
    n     = 16'd30;
    @(posedge CLK);
    #1;
    start = 1'b0;
    idle_cycles(5);
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b result=%0d err=%b, required all 0", busy, done, result, err);
    end
    #1;
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (done || busy) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL async_reset abandon: %0d active cycles, required 0", dones);
    end
    test_compute(16'd6);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    idle_cycles(2);
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
